logic_op_unit: RTL and testbench

//  Parametrised, pipelined successor to the single 2-input NOR gate.
//  - Reduces NUM_IN operands of WIDTH bits bitwise with a selectable op:
//    AND, OR, NAND, NOR, XOR, XNOR, NOT, PASS.
//  - Optional multi-beat accumulate mode.
//  - Valid/ready on both sides; registered output with a skid buffer.
//  - Drop-in logic stage for datapaths that need more than a fixed gate.

---
 rtl/logic_op_pkg.sv | 55 +++++
 rtl/logic_op_unit_if.sv | 27 ++
 rtl/logic_op_unit_skid_buffer.sv | 67 ++++++
 rtl/logic_op_unit.sv | 119 +++++++++++
 tb/tb_logic_op_unit.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_op_pkg.sv
// Shared op codes, FSM state type and bit-level reduction helpers for logic_op_unit.
// Bitwise ops are column-independent, so every helper works on a single bit column.
package logic_op_pkg;

  localparam int MAX_IN = 8;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_OR   = 3'd1;
  localparam op_t OP_NAND = 3'd2;
  localparam op_t OP_NOR  = 3'd3;
  localparam op_t OP_XOR  = 3'd4;
  localparam op_t OP_XNOR = 3'd5;
  localparam op_t OP_NOT  = 3'd6;
  localparam op_t OP_PASS = 3'd7;

  typedef enum logic {ST_IDLE, ST_ACCUM} state_t;

  // Inverting ops fold with their non-inverting twin; the invert is applied once at emit.
  function automatic op_t base_op(op_t op);
    case (op)
      OP_NAND: return OP_AND;
      OP_NOR:  return OP_OR;
      OP_XNOR: return OP_XOR;
      OP_NOT:  return OP_PASS;
      default: return op;
    endcase
  endfunction

  function automatic logic inv_op(op_t op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR) || (op == OP_NOT);
  endfunction

  function automatic logic combine_bit(op_t base, logic a, logic b);
    case (base)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return b;
    endcase
  endfunction

  function automatic logic reduce_bit(op_t base, logic [MAX_IN-1:0] col, int n);
    logic r;
    r = col[0];
    if (base != OP_PASS) begin
      for (int k = 1; k < MAX_IN; k++) begin
        if (k < n) r = combine_bit(base, r, col[k]);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/logic_op_unit_if.sv
// Valid/ready operand stream in, result stream out, for logic_op_unit.
interface logic_op_unit_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [2:0]              in_op;
  logic                    in_acc;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [CNT_W-1:0]        out_beats;

  modport master (
    output in_valid, in_data, in_op, in_acc, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_beats
  );

  modport slave (
    input  in_valid, in_data, in_op, in_acc, in_last, out_ready,
    output in_ready, out_valid, out_data, out_beats
  );
endinterface

// File: rtl/logic_op_unit_skid_buffer.sv
// Two-entry valid/ready register slice; entry 0 drives the output, entry 1 absorbs a stall.
// s_ready is registered and drops only when both entries are occupied.
module skid_buffer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data
);
  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] d0_q, d0_d, d1_q, d1_d;
  logic          ready_q;
  logic          pop;

  assign pop = (cnt_q != 2'd0) && m_ready;

  always_comb begin
    cnt_d = cnt_q;
    d0_d  = d0_q;
    d1_d  = d1_q;
    case ({s_valid, pop})
      2'b10: begin
        if (cnt_q == 2'd0) d0_d = s_data;
        else               d1_d = s_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        d0_d  = d1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          d0_d = d1_q;
          d1_d = s_data;
        end else begin
          d0_d = s_data;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: payload registers are reset too, because out_data must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      d0_q    <= '0;
      d1_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      ready_q <= (cnt_d != 2'd2);
    end
  end

  assign s_ready = ready_q;
  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = d0_q;
endmodule

// File: rtl/logic_op_unit.sv
// Pipelined bitwise reduction of NUM_IN operands with optional multi-beat accumulate,
// feeding a two-entry skid buffer that holds {out_beats, out_data}.
module logic_op_unit
  import logic_op_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 8
) (
  input logic            clk,
  input logic            rst,
  logic_op_unit_if.slave bus
);
  localparam int DW = CNT_W + WIDTH;

  state_t           state_q, state_d;
  op_t              grp_op_q, grp_op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] red_new, red_grp, fold;
  logic             space, in_ready, accept, push;
  logic [WIDTH-1:0] push_data;
  logic [CNT_W-1:0] push_beats;
  logic [DW-1:0]    out_word;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Reduce the incoming beat both with its own op (IDLE) and with the latched group op (ACCUM).
  always_comb begin
    logic [MAX_IN-1:0] col;
    col = '0;
    red_new = '0;
    red_grp = '0;
    fold    = '0;
    for (int b = 0; b < WIDTH; b++) begin
      col = '0;
      for (int k = 0; k < NUM_IN; k++) col[k] = bus.in_data[k*WIDTH+b];
      red_new[b] = reduce_bit(base_op(bus.in_op), col, NUM_IN);
      red_grp[b] = reduce_bit(base_op(grp_op_q), col, NUM_IN);
      fold[b]    = combine_bit(base_op(grp_op_q), acc_q[b], red_grp[b]);
    end
  end

  // A non-last beat in ACCUM never produces output, so it needs no free entry.
  assign in_ready = space || (state_q == ST_ACCUM && !bus.in_last);
  assign accept   = bus.in_valid && in_ready;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    grp_op_d   = grp_op_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    push_data  = '0;
    push_beats = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.in_acc && !bus.in_last) begin
            acc_d    = red_new;
            grp_op_d = bus.in_op;
            cnt_d    = CNT_W'(1);
            state_d  = ST_ACCUM;
          end else begin
            push       = 1'b1;
            push_data  = inv_op(bus.in_op) ? ~red_new : red_new;
            push_beats = CNT_W'(1);
          end
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_d = fold;
          if (bus.in_last) begin
            push       = 1'b1;
            push_data  = inv_op(grp_op_q) ? ~fold : fold;
            push_beats = sat_inc(cnt_q);
            state_d    = ST_IDLE;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grp_op_q <= OP_AND;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grp_op_q <= grp_op_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  skid_buffer #(.DW(DW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_valid (push),
    .s_data  ({push_beats, push_data}),
    .s_ready (space),
    .m_valid (bus.out_valid),
    .m_ready (bus.out_ready),
    .m_data  (out_word)
  );

  assign {bus.out_beats, bus.out_data} = out_word;
  assign bus.in_ready = in_ready;
endmodule

// File: tb/tb_logic_op_unit.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model,
// driving two instances (CNT_W=8 and CNT_W=2) with identical stimulus.
module tb_logic_op_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_op_unit_if #(.WIDTH(8), .NUM_IN(2), .CNT_W(8)) bus_a ();
  logic_op_unit_if #(.WIDTH(8), .NUM_IN(2), .CNT_W(2)) bus_b ();

  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.in_data   = bus_a.in_data;
  assign bus_b.in_op     = bus_a.in_op;
  assign bus_b.in_acc    = bus_a.in_acc;
  assign bus_b.in_last   = bus_a.in_last;
  assign bus_b.out_ready = bus_a.out_ready;

  logic_op_unit #(.WIDTH(8), .NUM_IN(2), .CNT_W(8)) u_dut (.clk(clk), .rst(rst), .bus(bus_a));
  logic_op_unit #(.WIDTH(8), .NUM_IN(2), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0] data;
    int         beats;
  } exp_t;

  exp_t       exp_q[$];
  bit         started = 1'b0;
  bit         prev_rst = 1'b0;
  bit         in_grp = 1'b0;
  bit         exp_ready;
  logic [2:0] g_op;
  logic [7:0] g_and, g_or, g_xor, g_op0;
  int         g_beats;

  function automatic logic [7:0] model_result(logic [2:0] op, logic [7:0] and_v, logic [7:0] or_v,
                                              logic [7:0] xor_v, logic [7:0] op0);
    logic [7:0] r;
    case (op)
      3'd0, 3'd2: r = and_v;
      3'd1, 3'd3: r = or_v;
      3'd4, 3'd5: r = xor_v;
      default:    r = op0;
    endcase
    if (op == 3'd2 || op == 3'd3 || op == 3'd5 || op == 3'd6) r = ~r;
    return r;
  endfunction

  function automatic int sat(int v, int max);
    return (v > max) ? max : v;
  endfunction

  task model_accept();
    logic [7:0] a, b;
    exp_t e;
    a = bus_a.in_data[7:0];
    b = bus_a.in_data[15:8];
    if (!in_grp) begin
      if (bus_a.in_acc && !bus_a.in_last) begin
        in_grp  = 1'b1;
        g_op    = bus_a.in_op;
        g_and   = a & b;
        g_or    = a | b;
        g_xor   = a ^ b;
        g_op0   = a;
        g_beats = 1;
      end else begin
        e.data  = model_result(bus_a.in_op, a & b, a | b, a ^ b, a);
        e.beats = 1;
        exp_q.push_back(e);
      end
    end else begin
      g_and   = g_and & a & b;
      g_or    = g_or | a | b;
      g_xor   = g_xor ^ a ^ b;
      g_op0   = a;
      g_beats = g_beats + 1;
      if (bus_a.in_last) begin
        e.data  = model_result(g_op, g_and, g_or, g_xor, g_op0);
        e.beats = g_beats;
        exp_q.push_back(e);
        in_grp = 1'b0;
      end
    end
  endtask

  // Compare every cycle at the falling edge, then advance the model to the coming rising edge.
  always @(negedge clk) begin
    if (started) begin
      if (prev_rst) begin
        check("rst_in_ready", bus_a.in_ready, 0);
        check("rst_out_valid", bus_a.out_valid, 0);
      end else begin
        exp_ready = (exp_q.size() < 2) || (in_grp && !bus_a.in_last);
        check("in_ready", bus_a.in_ready, exp_ready);
        check("in_ready_sat", bus_b.in_ready, exp_ready);
        check("out_valid", bus_a.out_valid, exp_q.size() != 0);
        check("out_valid_sat", bus_b.out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0 && bus_a.out_valid) begin
          check("out_data", bus_a.out_data, exp_q[0].data);
          check("out_data_sat", bus_b.out_data, exp_q[0].data);
          check("out_beats", bus_a.out_beats, sat(exp_q[0].beats, 255));
          check("out_beats_sat", bus_b.out_beats, sat(exp_q[0].beats, 3));
        end
      end
    end
    if (rst) begin
      exp_q.delete();
      in_grp  = 1'b0;
      started = 1'b1;
    end else if (started) begin
      if (bus_a.out_valid && bus_a.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (bus_a.in_valid && bus_a.in_ready) model_accept();
    end
    prev_rst = rst;
  end

  // ---------------- stimulus ----------------
  bit fixed_ready = 1'b1;
  bit rnd_mode = 1'b0;

  always @(posedge clk) begin
    #1;
    bus_a.out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : fixed_ready;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_a.in_valid = 1'b0;
    bus_a.in_acc   = 1'b0;
    bus_a.in_last  = 1'b0;
  endtask

  task automatic present(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic acc, input logic last);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = {b, a};
    bus_a.in_op    = op;
    bus_a.in_acc   = acc;
    bus_a.in_last  = last;
  endtask

  task automatic drive_beat(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                            input logic acc, input logic last);
    bit done;
    done = 1'b0;
    present(a, b, op, acc, last);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus_a.in_ready) done = 1'b1;
      step();
    end
    check("accept_in_time", done, 1);
  endtask

  logic [7:0] t2_exp[8] = '{8'h30, 8'hFC, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'h0F, 8'hF0};
  logic [7:0] t4_a[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] t6_a[5] = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h0F};
  logic [7:0] t6_b[5] = '{8'h02, 8'h08, 8'h20, 8'h80, 8'h00};

  initial begin
    int  n_acc;
    int  idx;
    bit  took;

    // T1: reset held with in_valid high
    rst = 1'b1;
    present(8'hAA, 8'h55, 3'd0, 1'b0, 1'b0);
    repeat (3) step();
    @(negedge clk);
    check("t1_in_ready", bus_a.in_ready, 0);
    check("t1_out_valid", bus_a.out_valid, 0);
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("t1_in_ready_before", bus_a.in_ready, 0);
    step();
    @(negedge clk);
    check("t1_in_ready_after", bus_a.in_ready, 1);
    step();

    // T2: op sweep, one result per beat one cycle later
    for (int op = 0; op < 8; op++) begin
      drive_beat(8'hF0, 8'h3C, 3'(op), 1'b0, 1'b0);
      idle();
      @(negedge clk);
      check("t2_valid", bus_a.out_valid, 1);
      check("t2_data", bus_a.out_data, t2_exp[op]);
      check("t2_beats", bus_a.out_beats, 1);
      step();
    end

    // T3: NOR group of three beats; later beats carry ops that must be ignored
    drive_beat(8'hF0, 8'h0F, 3'd3, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    check("t3_no_out1", bus_a.out_valid, 0);
    step();
    drive_beat(8'h01, 8'h00, 3'd1, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    check("t3_no_out2", bus_a.out_valid, 0);
    step();
    drive_beat(8'h00, 8'h80, 3'd5, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    check("t3_valid", bus_a.out_valid, 1);
    check("t3_data", bus_a.out_data, 8'h00);
    check("t3_beats", bus_a.out_beats, 3);
    check("t3_beats_sat", bus_b.out_beats, 3);
    step();

    // T4: backpressure fills both entries, then drains in order
    fixed_ready = 1'b0;
    step();
    step();
    n_acc = 0;
    idx = 0;
    present(t4_a[0], 8'h0F, 3'd4, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      took = bus_a.in_valid && bus_a.in_ready;
      if (took) n_acc++;
      step();
      if (took) begin
        idx++;
        if (idx < 4) present(t4_a[idx], 8'h0F, 3'd4, 1'b0, 1'b0);
        else idle();
      end
    end
    check("t4_accepted", n_acc, 2);
    @(negedge clk);
    check("t4_in_ready_low", bus_a.in_ready, 0);
    step();
    fixed_ready = 1'b1;
    while (idx < 4) begin
      drive_beat(t4_a[idx], 8'h0F, 3'd4, 1'b0, 1'b0);
      idx++;
    end
    idle();
    repeat (6) step();

    // T5: reset in the middle of a group discards it
    drive_beat(8'hFF, 8'h00, 3'd0, 1'b1, 1'b0);
    drive_beat(8'h0F, 8'h0F, 3'd0, 1'b1, 1'b0);
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t5_no_out", bus_a.out_valid, 0);
      step();
    end
    drive_beat(8'hFF, 8'h0F, 3'd0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("t5_data", bus_a.out_data, 8'h0F);
    check("t5_beats", bus_a.out_beats, 1);
    step();

    // T6: five-beat XOR group saturates the 2-bit counter
    for (int k = 0; k < 5; k++) drive_beat(t6_a[k], t6_b[k], 3'd4, 1'b1, 1'(k == 4));
    idle();
    @(negedge clk);
    check("t6_valid", bus_a.out_valid, 1);
    check("t6_data", bus_a.out_data, 8'hF0);
    check("t6_beats", bus_a.out_beats, 5);
    check("t6_beats_sat", bus_b.out_beats, 3);
    step();

    // Random traffic with random backpressure
    rnd_mode = 1'b1;
    repeat (300) begin
      drive_beat(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        step();
      end
    end
    drive_beat(8'h5A, 8'hA5, 3'd7, 1'b1, 1'b1);
    idle();
    rnd_mode = 1'b0;
    fixed_ready = 1'b1;
    repeat (10) step();
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    check("drain_out_valid", bus_a.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
